// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: pattern mode encodings,
// bounce-box size and helpers that derive raster totals and counter widths.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam int unsigned BOX_SIZE = 32;

  // Total pixels per line (or lines per frame) from the four timing segments.
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed for a counter running 0..total-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing core: h/v counters advanced by a pixel clock-enable, plus
// registered sync, data-enable, frame-start and coordinates of the pixel
// just processed. Raw counters and decodes are exported so the pattern stage
// can register its colour on the same edge as the timing outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = cnt_width(H_TOTAL),
  localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          pix_ce_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          first_o,
  output logic          line_last_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          frame_start_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o
);

  localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);
  localparam int            HSyncLo = int'(H_ACTIVE + H_FP);
  localparam int            HSyncHi = int'(H_ACTIVE + H_FP + H_SYNC);
  localparam int            VSyncLo = int'(V_ACTIVE + V_FP);
  localparam int            VSyncHi = int'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HsOn    = (HS_POL != 0);
  localparam logic          VsOn    = (VS_POL != 0);

  logic [HW-1:0] h_q, h_d, x_q;
  logic [VW-1:0] v_q, v_d, y_q;
  logic          h_last, v_last, h_sync, v_sync, active, first;
  logic          hsync_q, vsync_q, de_q, fs_q;

  assign h_last = (h_q == HLast);
  assign v_last = (v_q == VLast);
  assign h_sync = (int'(h_q) >= HSyncLo) && (int'(h_q) < HSyncHi);
  assign v_sync = (int'(v_q) >= VSyncLo) && (int'(v_q) < VSyncHi);
  assign active = (int'(h_q) < int'(H_ACTIVE)) && (int'(v_q) < int'(V_ACTIVE));
  assign first  = (h_q == '0) && (v_q == '0);

  // Next counter state: v steps on h wrap; the last pixel of the frame wraps both.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Counters and output registers; outputs describe the pixel just processed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~HsOn;
      vsync_q <= ~VsOn;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (pix_ce_i) begin
        hsync_q <= h_sync ? HsOn : ~HsOn;
        vsync_q <= v_sync ? VsOn : ~VsOn;
        de_q    <= active;
        fs_q    <= first;
        x_q     <= h_q;
        y_q     <= v_q;
      end
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign active_o      = active;
  assign first_o       = first;
  assign line_last_o   = h_last;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign x_o           = x_q;
  assign y_o           = y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster timing plus a registered RGB pattern
// stage aligned with sync/de. Patterns: solid white, eight colour bars,
// checkerboard, and (with VGA_BOUNCE_BOX_EN defined) a bouncing white box on
// blue; without the macro mode 3 renders solid white.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned CHK_LOG2 = 5,
  localparam int unsigned HW = cnt_width(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int unsigned VW = cnt_width(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               de,
  output logic               frame_start,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y
);

  localparam int unsigned   BarW    = H_ACTIVE / 8;
  localparam int unsigned   BW      = cnt_width(BarW);
  localparam logic [BW-1:0] BarLast = BW'(BarW - 1);

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               active, first, line_last;
  mode_e              mode_q, mode_eff;
  logic [BW-1:0]      bar_pix_q, bar_pix_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .clk_i         (clk),
    .reset_i       (reset),
    .pix_ce_i      (pix_ce),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active),
    .first_o       (first),
    .line_last_o   (line_last),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .de_o          (de),
    .frame_start_o (frame_start),
    .x_o           (x),
    .y_o           (y)
  );

  // The (0,0) pixel already uses the freshly sampled mode so a frame never mixes modes.
  assign mode_eff = first ? mode_e'(mode) : mode_q;

  // Frame-locked mode register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_SOLID;
    end else if (pix_ce && first) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Bar position tracks h_cnt: pixel-within-bar and bar index, cleared on line wrap.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (pix_ce) begin
      if (line_last) begin
        bar_pix_d = '0;
        bar_idx_d = '0;
      end else if (bar_pix_q == BarLast) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
      end
    end
  end

  // Bar sub-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_pix_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
    end
  end

`ifdef VGA_BOUNCE_BOX_EN
  localparam logic [HW-1:0] BxMax = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0] ByMax = VW'(V_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0] VLast = VW'(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);

  logic [HW-1:0] bx_q, bx_d;
  logic [VW-1:0] by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;  // 1 = moving towards 0
  logic          in_box;

  assign in_box = (int'(h_cnt) >= int'(bx_q)) && (int'(h_cnt) < int'(bx_q) + int'(BOX_SIZE)) &&
                  (int'(v_cnt) >= int'(by_q)) && (int'(v_cnt) < int'(by_q) + int'(BOX_SIZE));

  // Step the box on the last pixel of a frame so each frame draws one position.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (pix_ce && line_last && (v_cnt == VLast)) begin
      if (!dx_q) begin
        if (bx_q >= BxMax) begin
          bx_d = bx_q - 1'b1;
          dx_d = 1'b1;
        end else begin
          bx_d = bx_q + 1'b1;
        end
      end else if (bx_q == '0) begin
        bx_d = bx_q + 1'b1;
        dx_d = 1'b0;
      end else begin
        bx_d = bx_q - 1'b1;
      end
      if (!dy_q) begin
        if (by_q >= ByMax) begin
          by_d = by_q - 1'b1;
          dy_d = 1'b1;
        end else begin
          by_d = by_q + 1'b1;
        end
      end else if (by_q == '0) begin
        by_d = by_q + 1'b1;
        dy_d = 1'b0;
      end else begin
        by_d = by_q - 1'b1;
      end
    end
  end

  // Box position and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= 1'b0;
      dy_q <= 1'b0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
`endif

  // Pattern colour for the current counter position; blanking outside the active area.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      unique case (mode_eff)
        MODE_BARS: begin
          r_d = {COLOR_W{bar_idx_q[0]}};
          g_d = {COLOR_W{bar_idx_q[1]}};
          b_d = {COLOR_W{bar_idx_q[2]}};
        end
        MODE_CHECK: begin
          if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
          end
        end
        MODE_BOX: begin
`ifdef VGA_BOUNCE_BOX_EN
          r_d = in_box ? '1 : '0;
          g_d = in_box ? '1 : '0;
          b_d = '1;
`else
          r_d = '1;
          g_d = '1;
          b_d = '1;
`endif
        end
        default: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
      endcase
    end
  end

  // RGB output registers, loaded on the same enabled edge as the timing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (pix_ce) begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster (48x40 total) so several
// frames fit in the run. A pixel-index reference model checks every cycle;
// a vector table and hand sequences check fixed points and timing.
module tb_vga_pattern_gen;

  localparam int HA = 40, HF = 2, HSW = 4, HB = 2;
  localparam int VA = 36, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int CW = 4, CHK = 3, BW = HA / 8, BOX = 32;
  localparam logic HS_ON = 1'b0, VS_ON = 1'b1;
  localparam int XW = $clog2(HT), YW = $clog2(VT);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          fs;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } obs_t;

  typedef struct {
    logic [1:0]    mode;
    int            h;
    int            v;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          de;
  } vec_t;

  logic          clk = 1'b0, reset = 1'b1, pix_ce = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          hsync, vsync, de, frame_start;
  logic [CW-1:0] r, g, b;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  int         n_cmp = 0, n_fail = 0;
  int         p = 0;          // pixels processed since reset
  logic [1:0] fmode = 2'd0;   // mode latched for the current model frame
  obs_t       exp_o;
  vec_t       tbl[$];

  vga_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
    .HS_POL (0), .VS_POL (1), .COLOR_W (CW), .CHK_LOG2 (CHK)
  ) dut (
    .clk (clk), .reset (reset), .pix_ce (pix_ce), .mode (mode),
    .hsync (hsync), .vsync (vsync), .r (r), .g (g), .b (b),
    .de (de), .frame_start (frame_start), .x (x), .y (y)
  );

  always #5 clk = ~clk;

  function automatic int tri_pos(input int f, input int span);
    int t;
    if (span <= 0) return 0;
    t = f % (2 * span);
    return (t <= span) ? t : 2 * span - t;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = !HS_ON;
    o.vs = !VS_ON;
    return o;
  endfunction

  // Expected outputs for linear pixel index pp of frame f drawn in mode md.
  function automatic obs_t pixel_out(input int pp, input logic [1:0] md, input int f);
    obs_t o;
    int h, v, bar, bx, by;
    h = pp % HT;
    v = (pp / HT) % VT;
    o = '0;
    o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HS_ON : !HS_ON;
    o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VS_ON : !VS_ON;
    o.de = (h < HA) && (v < VA);
    o.fs = (h == 0) && (v == 0);
    o.x = XW'(h);
    o.y = YW'(v);
    bx = 0;
    by = 0;
    if (o.de) begin
      case (md)
        2'd1: begin
          bar = h / BW;
          o.r = (bar % 2 != 0) ? '1 : '0;
          o.g = ((bar / 2) % 2 != 0) ? '1 : '0;
          o.b = ((bar / 4) % 2 != 0) ? '1 : '0;
        end
        2'd2: begin
          if ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) begin
            o.r = '1; o.g = '1; o.b = '1;
          end
        end
        2'd3: begin
`ifdef VGA_BOUNCE_BOX_EN
          bx = tri_pos(f, HA - BOX);
          by = tri_pos(f, VA - BOX);
          if (h >= bx && h < bx + BOX && v >= by && v < by + BOX) begin
            o.r = '1; o.g = '1; o.b = '1;
          end else begin
            o.b = '1;
          end
`else
          o.r = '1; o.g = '1; o.b = '1;
`endif
        end
        default: begin
          o.r = '1; o.g = '1; o.b = '1;
        end
      endcase
    end
    return o;
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs #1 after the edge.
  task automatic apply(input logic rst, input logic ce, input logic [1:0] md, input string nm);
    obs_t got;
    reset = rst;
    pix_ce = ce;
    mode = md;
    @(posedge clk);
    if (rst) begin
      exp_o = reset_obs();
      p = 0;
    end else if (ce) begin
      if (p % FT == 0) fmode = md;
      exp_o = pixel_out(p, fmode, p / FT);
      p++;
    end
    #1;
    got = '{hs: hsync, vs: vsync, de: de, fs: frame_start, x: x, y: y, r: r, g: g, b: b};
    n_cmp++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL model/%s pix=%0d: got %h expected %h", nm, p, got, exp_o);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Enabled pixels until the model has processed linear pixel 'target'.
  task automatic run_to(input int target, input logic [1:0] md);
    while (p <= target) apply(1'b0, 1'b1, md, "run");
  endtask

  task automatic add_vec(input logic [1:0] md, input int h, input int v, input logic [CW-1:0] er,
                         input logic [CW-1:0] eg, input logic [CW-1:0] eb, input logic ede);
    vec_t t;
    t.mode = md; t.h = h; t.v = v; t.r = er; t.g = eg; t.b = eb; t.de = ede;
    tbl.push_back(t);
  endtask

  initial begin
    int first_hs, hs_cnt, vs_cnt, first_vs, fs1, fs2, rise1, rise2;
    logic prev_fs;
    logic [1:0] cur_mode;

    // Vector table: fixed pixels of the first frame after reset.
    add_vec(2'd0,  0,  0, 4'hF, 4'hF, 4'hF, 1'b1);
    add_vec(2'd0, 39, 35, 4'hF, 4'hF, 4'hF, 1'b1);
    add_vec(2'd0, 40,  0, 4'h0, 4'h0, 4'h0, 1'b0);
    add_vec(2'd0,  0, 36, 4'h0, 4'h0, 4'h0, 1'b0);
    add_vec(2'd1,  4, 10, 4'h0, 4'h0, 4'h0, 1'b1);
    add_vec(2'd1,  5, 10, 4'hF, 4'h0, 4'h0, 1'b1);
    add_vec(2'd1, 10, 10, 4'h0, 4'hF, 4'h0, 1'b1);
    add_vec(2'd1, 20, 10, 4'h0, 4'h0, 4'hF, 1'b1);
    add_vec(2'd1, 39, 10, 4'hF, 4'hF, 4'hF, 1'b1);
    add_vec(2'd1, 40, 10, 4'h0, 4'h0, 4'h0, 1'b0);
    add_vec(2'd2,  8,  0, 4'hF, 4'hF, 4'hF, 1'b1);
    add_vec(2'd2,  8,  8, 4'h0, 4'h0, 4'h0, 1'b1);
    add_vec(2'd2,  0,  8, 4'hF, 4'hF, 4'hF, 1'b1);
    add_vec(2'd2,  7,  7, 4'h0, 4'h0, 4'h0, 1'b1);
    add_vec(2'd3, 31, 31, 4'hF, 4'hF, 4'hF, 1'b1);
`ifdef VGA_BOUNCE_BOX_EN
    add_vec(2'd3, 32,  0, 4'h0, 4'h0, 4'hF, 1'b1);
`else
    add_vec(2'd3, 32,  0, 4'hF, 4'hF, 4'hF, 1'b1);
`endif

    // Reset state.
    apply(1'b1, 1'b1, 2'd0, "reset");
    check_val("rst_hsync", int'(hsync), int'(!HS_ON));
    check_val("rst_vsync", int'(vsync), int'(!VS_ON));
    check_val("rst_de_fs", int'({de, frame_start}), 0);
    check_val("rst_rgb", int'({r, g, b}), 0);
    check_val("rst_xy", int'({x, y}), 0);

    // Sync placement and widths, frame period with constant enable.
    first_hs = -1; hs_cnt = 0; vs_cnt = 0; first_vs = -1; fs1 = -1; fs2 = -1;
    for (int k = 1; k <= FT + 1; k++) begin
      apply(1'b0, 1'b1, 2'd0, "sync");
      if (hsync == HS_ON && k <= HT) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = k;
      end
      if (vsync == VS_ON && k <= FT) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = k;
      end
      if (frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    check_val("hsync_start", first_hs, HA + HF + 1);
    check_val("hsync_width", hs_cnt, HSW);
    check_val("vsync_start", first_vs, (VA + VF) * HT + 1);
    check_val("vsync_width", vs_cnt, VSW * HT);
    check_val("first_fs", fs1, 1);
    check_val("frame_period", fs2 - fs1, FT);

    // Alternating enable doubles the frame period.
    apply(1'b1, 1'b1, 2'd0, "reset");
    rise1 = -1; rise2 = -1; prev_fs = 1'b0;
    for (int k = 1; k <= 2 * FT + 4; k++) begin
      apply(1'b0, logic'(k % 2), 2'd1, "toggle");
      if (frame_start && !prev_fs) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev_fs = frame_start;
    end
    check_val("toggle_period", rise2 - rise1, 2 * FT);

    // Table of fixed pixels, each from a fresh reset.
    foreach (tbl[i]) begin
      apply(1'b1, 1'b1, tbl[i].mode, "tbl_reset");
      run_to(tbl[i].h + tbl[i].v * HT, tbl[i].mode);
      check_val($sformatf("tbl%0d_xy", i), int'({x, y}), (tbl[i].h << YW) | tbl[i].v);
      check_val($sformatf("tbl%0d_de", i), int'(de), int'(tbl[i].de));
      check_val($sformatf("tbl%0d_rgb", i), int'({r, g, b}),
                int'({tbl[i].r, tbl[i].g, tbl[i].b}));
    end

    // Mid-frame mode change only takes effect at the next frame.
    apply(1'b1, 1'b1, 2'd0, "reset");
    run_to(10 + 10 * HT, 2'd0);
    run_to(16 + 20 * HT, 2'd2);
    check_val("modechg_same_frame", int'({r, g, b}), 12'hFFF);
    run_to(FT + 8, 2'd2);
    check_val("modechg_next_white", int'({r, g, b}), 12'hFFF);
    run_to(FT + 8 + 8 * HT, 2'd2);
    check_val("modechg_next_black", int'({de, r, g, b}), 13'h1000);

    // Reset while both syncs are active restarts the raster.
    apply(1'b1, 1'b1, 2'd2, "reset");
    run_to(43 + 37 * HT, 2'd2);
    check_val("pre_rst_syncs", int'({hsync, vsync}), int'({HS_ON, VS_ON}));
    apply(1'b1, 1'b1, 2'd2, "mid_reset");
    check_val("mid_rst_syncs", int'({hsync, vsync}), int'({!HS_ON, !VS_ON}));
    apply(1'b0, 1'b1, 2'd2, "after_reset");
    check_val("after_rst_fs", int'(frame_start), 1);
    check_val("after_rst_xy", int'({x, y}), 0);

    // Randomised enable and occasional mode changes against the model.
    apply(1'b1, 1'b1, 2'd3, "reset");
    cur_mode = 2'd3;
    for (int k = 0; k < 30000; k++) begin
      if ($urandom_range(699, 0) == 0) cur_mode = 2'($urandom_range(3, 0));
      apply(1'b0, ($urandom_range(3, 0) != 0), cur_mode, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
